cpu_pace_ctrl: RTL
==================

# cpu_pace_ctrl

Parametrised CPU pacing controller for the NES core: holds the CPU delay setting, adjustable by the faster/slower push buttons and by Avalon-style register writes from the HPS. Generates the CPU clock-enable pulse `cpu_en` at a rate set by the delay and prescaler. Sequences CPU reset, run, pause and single-step under host command. Sits between the HPS bus bridge, the board buttons and the 6502 core's enable and reset inputs.

## Interface
- `DELAY_W`, 4: delay register width.
- `DELAY_MIN`, 1: smallest legal delay (≥1).
- `DELAY_MAX`, 15: largest legal delay (≤2^DELAY_W−1).
- `DELAY_INIT`, 8: delay after reset.
- `PRESCALE_W`, 16: prescaler register width (≤16).
- `PRESCALE_INIT`, 0: prescaler value after reset.
- `RESET_HOLD`, 4: cycles `cpu_reset` is held per reset sequence (≥1).
- `DEBOUNCE_CYCLES`, 50000: stability window; used only with the debounce macro.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `faster` in 1: raw push button, active-high, asynchronous to `clk`.
- `slower` in 1: raw push button, active-high, asynchronous to `clk`.
- `write` in 1: bus write strobe, one cycle per write.
- `read` in 1: bus read strobe.
- `address` in 16: register address; only bits [1:0] are decoded.
- `writedata` in 16: write data.
- `readdata` out 16: registered read data.
- `delay` out DELAY_W: current delay value.
- `cpu_en` out 1: one-cycle CPU clock-enable pulse.
- `cpu_reset` out 1: CPU reset, active-high.
- `running` out 1: high in the RUN state.

## Operation
- Register map by address[1:0]:
  - 0 CMD (write only). writedata[7:0]: 0 RESET_CPU, 1 START_CPU, 2 PAUSE_CPU, 4 STEP_CPU. Code 3 (WRITE_MEM) and all other codes are ignored.
  - 1 DELAY (read/write). Writes are clamped to [DELAY_MIN, DELAY_MAX] using writedata[15:0] compared unsigned before truncation.
  - 2 PRESCALE (read/write). Uses writedata[PRESCALE_W-1:0].
  - 3 TICKS (read only). 16-bit count of `cpu_en` pulses. Wraps at 0xFFFF→0. Cleared on entry to HOLD.
  - Reading CMD returns {14'b0, running, cpu_reset}. Unused readdata bits are 0.
- Buttons:
  - Each button passes through a 2-flop synchroniser, then the optional debounce filter, then a rising-edge detector.
  - Each press gives one step; holding a button does not repeat.
  - faster edge: delay−1, unless delay==DELAY_MIN.
  - slower edge: delay+1, unless delay==DELAY_MAX.
  - Both edges in the same cycle: no change.
  - A DELAY write in the same cycle as a button edge: the write wins and the edge is dropped.
- State machine (HOLD, PAUSED, RUN):
  - HOLD: `cpu_reset`=1, no `cpu_en`. Hold counter counts RESET_HOLD cycles, then the state goes to PAUSED. TICKS is cleared.
  - PAUSED: `cpu_en` only from STEP_CPU, which gives exactly one pulse on the following cycle. START_CPU goes to RUN.
  - RUN: periodic `cpu_en`. PAUSE_CPU goes to PAUSED. STEP_CPU is ignored.
  - RESET_CPU in any state, including mid-HOLD, enters HOLD and reloads the hold counter.
  - START_CPU while in HOLD is ignored.
- Pace generator (active in RUN only):
  - Prescaler counts 0..PRESCALE. On wrap, the unit counter advances.
  - When the unit counter reaches delay−1 and the prescaler wraps, `cpu_en` pulses and the unit counter clears.
  - Period is delay×(PRESCALE+1) cycles.
  - Both counters clear on: any change of delay, a PRESCALE write, entering RUN, or leaving RUN.

## Timing
- Values on async reset: state=HOLD with hold counter loaded, delay=DELAY_INIT, PRESCALE=PRESCALE_INIT, TICKS=0, readdata=0, cpu_en=0, cpu_reset=1, running=0, all synchroniser/filter/edge flops 0.
- After reset deassert, `cpu_reset` stays high for RESET_HOLD cycles.
- Register writes take effect on the clock edge where `write` is sampled high.
- readdata is valid one cycle after `read` and holds until the next read.
- Command latency from the write edge:
  - START_CPU: `running` rises 1 cycle after the write edge; the first `cpu_en` pulse occurs exactly one period after `running` rises.
  - PAUSE_CPU: no `cpu_en` is issued from the cycle after the write edge.
  - STEP_CPU: the `cpu_en` pulse is asserted in the cycle immediately after the write edge.
- Button latency, no debounce: the button is first sampled high at edge N; `delay` updates at edge N+2.
- `cpu_en` is never high for two consecutive cycles except when delay×(PRESCALE+1)==1.

## Configuration
- `CPU_PACE_DEBOUNCE_EN` defined:
  - Each synchronised button feeds a per-button counter.
  - The filtered level changes only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Button latency becomes N+2+DEBOUNCE_CYCLES.
  - Glitches shorter than the window produce no step.
- Not defined: filtered level = synchroniser output, no counters are instantiated, and DEBOUNCE_CYCLES is unused.

## Test plan
- Reset, then idle: `cpu_reset`=1 for 4 cycles, then 0; delay=8; running=0; no `cpu_en`; readdata of TICKS=0.
- Write DELAY=0 -> delay=1. Write DELAY=0x00FF -> delay=15. Hold faster 20 cycles from delay=8 -> delay=7 (one step only).
- Pulse faster and slower in the same cycle at delay=8 -> delay stays 8. DELAY write of 3 coinciding with a slower edge -> delay=3.
- PRESCALE=1, delay=3, START_CPU -> `cpu_en` every 6 cycles. Slower press mid-period -> counters clear and the period becomes 8 cycles.
- PAUSE_CPU, then three STEP_CPU writes -> exactly 3 `cpu_en` pulses, each one cycle after its write; TICKS advances by 3. RESET_CPU -> TICKS reads 0 and `cpu_reset` is high 4 cycles.
- With `CPU_PACE_DEBOUNCE_EN` and DEBOUNCE_CYCLES=8: a 5-cycle faster glitch -> no change; a 12-cycle press -> delay−1 at edge N+10.

Source files
------------

// File: rtl/cpu_pace_ctrl.sv
// cpu_pace_ctrl: CPU pacing controller for the NES core.
// Holds the CPU delay (buttons + HPS register writes), generates the periodic
// cpu_en pulse, and sequences CPU hold/pause/run/single-step.
// Optional build macro: CPU_PACE_DEBOUNCE_EN adds a per-button stability filter
// of DEBOUNCE_CYCLES cycles between the synchroniser and the edge detector.
module cpu_pace_ctrl #(
  parameter int DELAY_W         = 4,
  parameter int DELAY_MIN       = 1,
  parameter int DELAY_MAX       = 15,
  parameter int DELAY_INIT      = 8,
  parameter int PRESCALE_W      = 16,
  parameter int PRESCALE_INIT   = 0,
  parameter int RESET_HOLD      = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               faster,
  input  logic               slower,
  input  logic               write,
  input  logic               read,
  input  logic [15:0]        address,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic [DELAY_W-1:0] delay,
  output logic               cpu_en,
  output logic               cpu_reset,
  output logic               running
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  typedef enum logic [1:0] {ST_HOLD, ST_PAUSED, ST_RUN} state_t;

  state_t                  state_q;
  logic [HOLD_W-1:0]       hold_q;
  logic                    cpu_reset_q, running_q, cpu_en_q, cpu_en_d;
  logic [DELAY_W-1:0]      delay_q, delay_d, dly_m1, unit_q;
  logic [PRESCALE_W-1:0]   prescale_q, pre_q;
  logic [15:0]             ticks_q, readdata_q;

  // ---------------- bus decode ----------------
  logic cmd_wr, dly_wr, ps_wr;
  logic cmd_reset, cmd_start, cmd_pause, cmd_step;
  assign cmd_wr    = write && (address[1:0] == 2'd0);
  assign dly_wr    = write && (address[1:0] == 2'd1);
  assign ps_wr     = write && (address[1:0] == 2'd2);
  assign cmd_reset = cmd_wr && (writedata[7:0] == 8'd0);
  assign cmd_start = cmd_wr && (writedata[7:0] == 8'd1);
  assign cmd_pause = cmd_wr && (writedata[7:0] == 8'd2);
  assign cmd_step  = cmd_wr && (writedata[7:0] == 8'd4);

  // Upper address bits are not decoded; the debounce window is only consumed
  // when the filter is built in.
  logic unused_ok;
  assign unused_ok = ^{address[15:2], 32'(DEBOUNCE_CYCLES)};

  // ---------------- buttons: sync -> (filter) -> rising edge ----------------
  // bit 0 = faster, bit 1 = slower
  logic [1:0] sync1_q, sync2_q, lvl, prev_q, btn_edge;

  // Two-flop synchroniser for the asynchronous push buttons
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {slower, faster};
      sync2_q <= sync1_q;
    end
  end

`ifdef CPU_PACE_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  for (genvar b = 0; b < 2; b++) begin : g_db
    logic [DB_W-1:0] cnt_q;
    logic            filt_q;
    // Level follows the synchronised input only after it has disagreed for a full window
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q  <= '0;
        filt_q <= 1'b0;
      end else if (sync2_q[b] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_q <= sync2_q[b];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign lvl[b] = filt_q;
  end
`else
  assign lvl = sync2_q;
`endif

  // Previous filtered level for rising-edge detection (one step per press)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= '0;
    else       prev_q <= lvl;
  end
  assign btn_edge = lvl & ~prev_q;

  // ---------------- delay register ----------------
  // Next delay: a bus write beats any button edge; simultaneous edges cancel
  always_comb begin
    delay_d = delay_q;
    if (dly_wr) begin
      if (writedata < 16'(DELAY_MIN))      delay_d = DELAY_W'(DELAY_MIN);
      else if (writedata > 16'(DELAY_MAX)) delay_d = DELAY_W'(DELAY_MAX);
      else                                 delay_d = writedata[DELAY_W-1:0];
    end else if (btn_edge == 2'b01 && delay_q != DELAY_W'(DELAY_MIN)) begin
      delay_d = delay_q - 1'b1;
    end else if (btn_edge == 2'b10 && delay_q != DELAY_W'(DELAY_MAX)) begin
      delay_d = delay_q + 1'b1;
    end
  end

  // Delay and prescale configuration registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      delay_q    <= DELAY_W'(DELAY_INIT);
      prescale_q <= PRESCALE_W'(PRESCALE_INIT);
    end else begin
      delay_q <= delay_d;
      if (ps_wr) prescale_q <= writedata[PRESCALE_W-1:0];
    end
  end

  // ---------------- control FSM ----------------
  // HOLD -> PAUSED after RESET_HOLD cycles; PAUSED <-> RUN by start/pause
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      hold_q      <= HOLD_W'(RESET_HOLD - 1);
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
    end else if (cmd_reset) begin
      state_q     <= ST_HOLD;
      hold_q      <= HOLD_W'(RESET_HOLD - 1);
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_q == '0) begin
            state_q     <= ST_PAUSED;
            cpu_reset_q <= 1'b0;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        ST_PAUSED: if (cmd_start) begin
          state_q   <= ST_RUN;
          running_q <= 1'b1;
        end
        ST_RUN: if (cmd_pause) begin
          state_q   <= ST_PAUSED;
          running_q <= 1'b0;
        end
        default: state_q <= ST_HOLD;
      endcase
    end
  end

  // ---------------- pace generator ----------------
  logic in_run, enter_run, leave_run, pace_clr, pre_wrap, unit_last, pace_fire, step_fire;
  assign in_run    = (state_q == ST_RUN);
  assign enter_run = cmd_start && (state_q == ST_PAUSED);
  assign leave_run = in_run && (cmd_reset || cmd_pause);
  assign pace_clr  = (delay_d != delay_q) || ps_wr || enter_run || leave_run;
  assign dly_m1    = delay_q - 1'b1;
  assign pre_wrap  = (pre_q == prescale_q);
  assign unit_last = (unit_q == dly_m1);
  // A cycle that restarts the period never fires; leaving RUN suppresses it too
  assign pace_fire = in_run && !pace_clr && pre_wrap && unit_last;
  assign step_fire = cmd_step && (state_q == ST_PAUSED);
  assign cpu_en_d  = pace_fire || step_fire;

  // Prescaler and unit counter; they only advance while running
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q  <= '0;
      unit_q <= '0;
    end else if (pace_clr) begin
      pre_q  <= '0;
      unit_q <= '0;
    end else if (in_run) begin
      if (pre_wrap) begin
        pre_q  <= '0;
        unit_q <= unit_last ? '0 : unit_q + 1'b1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end

  // Registered enable pulse and pulse counter (cleared on entry to HOLD)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_en_q <= 1'b0;
      ticks_q  <= '0;
    end else begin
      cpu_en_q <= cpu_en_d;
      if (cmd_reset)     ticks_q <= '0;
      else if (cpu_en_d) ticks_q <= ticks_q + 1'b1;
    end
  end

  // ---------------- read port ----------------
  // Read data is captured on the read strobe and held until the next read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_q <= '0;
    end else if (read) begin
      case (address[1:0])
        2'd0:    readdata_q <= {14'b0, running_q, cpu_reset_q};
        2'd1:    readdata_q <= 16'(delay_q);
        2'd2:    readdata_q <= 16'(prescale_q);
        default: readdata_q <= ticks_q;
      endcase
    end
  end

  assign readdata  = readdata_q;
  assign delay     = delay_q;
  assign cpu_en    = cpu_en_q;
  assign cpu_reset = cpu_reset_q;
  assign running   = running_q;

endmodule
